// File: rtl/bgd_div_seq_13s_pkg.sv
// Shared types and constants for the BGD sequential signed divider.
package bgd_div_pkg;

  localparam int BGD_DIV_WIDTH = 13;

  // Divide-by-zero saturation values (+4095 and -4095)
  localparam logic [BGD_DIV_WIDTH-1:0] BGD_DIV_QMAX     = 13'h0FFF;
  localparam logic [BGD_DIV_WIDTH-1:0] BGD_DIV_QMIN_SAT = 13'h1001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } bgd_div_state_e;

endpackage

// File: rtl/bgd_div_seq_13s_if.sv
// Operand/result handshake bundle for bgd_div_seq_13s.
// The remainder signal exists only when BGD_DIV_REM_EN is defined.
interface bgd_div_seq_13s_if
  import bgd_div_pkg::*;
#(
  parameter int WIDTH = BGD_DIV_WIDTH
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] quotient;
`ifdef BGD_DIV_REM_EN
  logic signed [WIDTH-1:0] remainder;
`endif
  logic                    dbz;
  logic                    ovf;

`ifdef BGD_DIV_REM_EN
  modport master (output in_valid, dividend, divisor, out_ready,
                  input  in_ready, out_valid, quotient, remainder, dbz, ovf);
  modport slave  (input  in_valid, dividend, divisor, out_ready,
                  output in_ready, out_valid, quotient, remainder, dbz, ovf);
`else
  modport master (output in_valid, dividend, divisor, out_ready,
                  input  in_ready, out_valid, quotient, dbz, ovf);
  modport slave  (input  in_valid, dividend, divisor, out_ready,
                  output in_ready, out_valid, quotient, dbz, ovf);
`endif
endinterface

// File: rtl/bgd_div_seq_13s_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module bgd_div_step
  import bgd_div_pkg::*;
#(
  parameter int WIDTH = BGD_DIV_WIDTH
) (
  input  logic [WIDTH:0] i_rem,
  input  logic [WIDTH:0] i_dmag,
  input  logic           i_bit,
  output logic [WIDTH:0] o_rem,
  output logic           o_qbit
);
  logic [WIDTH+1:0] w_shift;
  logic             w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_dmag});
  assign o_qbit  = w_ge;
  assign o_rem   = w_ge ? (WIDTH+1)'(w_shift - {1'b0, i_dmag}) : w_shift[WIDTH:0];

endmodule

// File: rtl/bgd_div_seq_13s.sv
// Sequential signed restoring divider, one quotient bit per enabled cycle.
// Define BGD_DIV_REM_EN to add the sign-corrected remainder output.
module bgd_div_seq_13s
  import bgd_div_pkg::*;
#(
  parameter int WIDTH = BGD_DIV_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  bgd_div_seq_13s_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  bgd_div_state_e   r_state;
  bgd_div_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   r_dmag;
  logic [WIDTH-1:0] r_q;
  logic             r_neg_dvd;
  logic             r_neg_dvs;
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_quot;
  logic             r_dbz;
  logic             r_ovf;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH:0]   w_dvd_mag;
  logic             w_qbit;
  logic             w_zero_dvs;
`ifdef BGD_DIV_REM_EN
  logic [WIDTH-1:0] r_remo;
`endif

  function automatic logic [WIDTH:0] f_mag(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] x;
    x = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] m,
                                                    input logic neg);
    return neg ? -m : m;
  endfunction

  function automatic logic [WIDTH-1:0] f_sat_quot(input logic [WIDTH-1:0] qm,
                                                  input logic q_neg,
                                                  input logic dbz,
                                                  input logic dvd_neg);
    if (dbz) return dvd_neg ? BGD_DIV_QMIN_SAT : BGD_DIV_QMAX;
    return f_apply_sign(qm, q_neg);
  endfunction

  assign w_dvd_mag  = f_mag(bus.dividend);
  assign w_zero_dvs = (bus.divisor == '0);

  bgd_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_dmag (r_dmag),
    .i_bit  (r_q[WIDTH-1]),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset)   r_state <= IDLE;
    else if (ce) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_state_nxt = w_zero_dvs ? FIX : CALC;
      CALC: if (r_cnt == '0)  w_state_nxt = FIX;
      FIX:                    w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // r_q starts as |dividend| and fills with quotient bits from the right.
  // On divide-by-zero r_rem is loaded with |dividend| so FIX returns the dividend.
  always_ff @(posedge clk) begin
    if (ce) begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_neg_dvd  <= bus.dividend[WIDTH-1];
          r_neg_dvs  <= bus.divisor[WIDTH-1];
          r_dmag     <= f_mag(bus.divisor);
          r_q        <= w_dvd_mag[WIDTH-1:0];
          r_rem      <= w_zero_dvs ? w_dvd_mag : '0;
          r_dbz_pend <= w_zero_dvs;
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[WIDTH-2:0], w_qbit};
        end
        default: ;
      endcase
    end
  end

  // Overflow only arises as +4096, i.e. the magnitude MSB with like signs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_quot <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
`ifdef BGD_DIV_REM_EN
      r_remo <= '0;
`endif
    end else if (ce) begin
      case (r_state)
        IDLE: if (bus.in_valid) r_cnt <= CNT_W'(WIDTH-1);
        CALC: r_cnt <= r_cnt - CNT_W'(1);
        FIX: begin
          r_quot <= f_sat_quot(r_q, r_neg_dvd ^ r_neg_dvs, r_dbz_pend, r_neg_dvd);
          r_dbz  <= r_dbz_pend;
          r_ovf  <= !r_dbz_pend && !(r_neg_dvd ^ r_neg_dvs) && r_q[WIDTH-1];
`ifdef BGD_DIV_REM_EN
          r_remo <= f_apply_sign(r_rem[WIDTH-1:0], r_neg_dvd);
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && ce;
  assign bus.out_valid = (r_state == DONE);
  assign bus.quotient  = r_quot;
  assign bus.dbz       = r_dbz;
  assign bus.ovf       = r_ovf;
`ifdef BGD_DIV_REM_EN
  assign bus.remainder = r_remo;
`endif

endmodule

// File: tb/tb_bgd_div_seq_13s.sv
// Directed-vector bench for bgd_div_seq_13s: arithmetic, flags, latency,
// clock-enable stalls, backpressure and mid-operation reset.
module tb_bgd_div_seq_13s;
  import bgd_div_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  bgd_div_seq_13s_if bus ();

  bgd_div_seq_13s dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int ovf;
    int lat;
  } vec_t;

  vec_t vecs [10] = '{
    '{  100,     7,    14,    2, 0, 0, 15},
    '{ -100,     7,   -14,   -2, 0, 0, 15},
    '{  100,    -7,   -14,    2, 0, 0, 15},
    '{    5,     0,  4095,    5, 1, 0,  2},
    '{   -5,     0, -4095,   -5, 1, 0,  2},
    '{-4096,    -1, -4096,    0, 0, 1, 15},
    '{-4096,     1, -4096,    0, 0, 0, 15},
    '{    0,     5,     0,    0, 0, 0, 15},
    '{ 4095, -4096,     0, 4095, 0, 0, 15},
    '{-4096, -4096,     1,    0, 0, 0, 15}
  };

  task automatic wait_valid(inout int n);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_div(input vec_t v);
    int    n;
    string id;
    id = $sformatf("%0d/%0d", v.a, v.b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 13'(v.a);
    bus.divisor  = 13'(v.b);
    check({"in_ready ", id}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    n = 1;
    wait_valid(n);
    check({"latency ", id}, n, v.lat);
    check({"quotient ", id}, int'(bus.quotient), v.q);
`ifdef BGD_DIV_REM_EN
    check({"remainder ", id}, int'(bus.remainder), v.r);
`endif
    check({"dbz ", id}, int'(bus.dbz), v.dbz);
    check({"ovf ", id}, int'(bus.ovf), v.ovf);
    @(negedge clk);
    check({"out_valid_clr ", id}, int'(bus.out_valid), 0);
    check({"in_ready_back ", id}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int n;
    int stale;
    vec_t v94;

    reset         = 1'b1;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst in_ready", int'(bus.in_ready), 1);
    check("rst quotient", int'(bus.quotient), 0);
    check("rst dbz", int'(bus.dbz), 0);
    check("rst ovf", int'(bus.ovf), 0);
`ifdef BGD_DIV_REM_EN
    check("rst remainder", int'(bus.remainder), 0);
`endif
    ce = 1'b0;
    #1;
    check("in_ready ce0", int'(bus.in_ready), 0);
    ce = 1'b1;

    foreach (vecs[i]) run_div(vecs[i]);

    // 1000/3 with a 3-cycle ce stall during CALC and 10 cycles of backpressure
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 13'(1000);
    bus.divisor  = 13'(3);
    check("bp in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.dividend = 13'(55);
    bus.divisor  = 13'(5);
    check("bp busy in_ready", int'(bus.in_ready), 0);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      ce = !(n >= 2 && n < 5);
      @(negedge clk);
      n++;
    end
    ce           = 1'b1;
    bus.in_valid = 1'b0;
    check("bp latency", n, 18);
    check("bp quotient", int'(bus.quotient), 333);
`ifdef BGD_DIV_REM_EN
    check("bp remainder", int'(bus.remainder), 1);
`endif
    repeat (10) @(negedge clk);
    check("bp hold out_valid", int'(bus.out_valid), 1);
    check("bp hold quotient", int'(bus.quotient), 333);
`ifdef BGD_DIV_REM_EN
    check("bp hold remainder", int'(bus.remainder), 1);
`endif
    check("bp hold in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp out_valid_clr", int'(bus.out_valid), 0);
    check("bp in_ready_back", int'(bus.in_ready), 1);

    // Reset five cycles into 77/2, then 9/4 must come back clean
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 13'(77);
    bus.divisor  = 13'(2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort out_valid", int'(bus.out_valid), 0);
    check("abort in_ready", int'(bus.in_ready), 1);
    check("abort quotient", int'(bus.quotient), 0);
    reset = 1'b0;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("abort stale output", stale, 0);
    v94 = '{9, 4, 2, 1, 0, 0, 15};
    run_div(v94);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
